// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester mux-select arbiter and the mux it drives.
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  // Downstream 2:1 mux ctl values.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StGntA = ST_GNT_A,
    StGntB = ST_GNT_B
  } arb_state_e;

  typedef enum logic {
    ServedA = 1'b0,
    ServedB = 1'b1
  } served_e;

  // Round-robin tie break: whoever was not served last wins.
  function automatic arb_state_e rr_pick(served_e last_served);
    return (last_served == ServedB) ? StGntA : StGntB;
  endfunction

  // Mux select implied by a grant state; idle keeps the previous select.
  function automatic logic sel_for(arb_state_e st, logic sel_prev);
    case (st)
      StGntA:  return SEL_A;
      StGntB:  return SEL_B;
      default: return sel_prev;
    endcase
  endfunction

endpackage

// File: rtl/mux_select_arbiter_hold_timer.sv
// Grant hold counter: expires on the MAX_HOLD-th consecutive enabled cycle.
// MAX_HOLD=0 removes the counter and never expires.
module hold_timer #(
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (MAX_HOLD == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = clk ^ rst_n ^ clear ^ enable;
    assign expire        = 1'b0;
  end else begin : g_enabled
    localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = enable && (cnt_q == LastCnt);

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable) begin
        cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Two-requester round-robin arbiter producing the registered select for a 2:1 data mux.
// Grants are held until done, request drop, or hold timeout; all outputs are registered.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic done_a,
  input  logic done_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy,
  output logic timeout
);

  arb_state_e state_q, state_d;
  served_e    last_q, last_d;
  logic       sel_q, sel_d;
  logic       timeout_q, timeout_d;
  logic       gnt_a_q, gnt_b_q, busy_q;
  logic       release_grant;
  logic       expire;
  logic       timer_clear;
  logic       timer_enable;

  assign timer_enable = (state_q != StIdle);
  // Idle keeps the counter at zero so every grant starts a fresh hold window.
  assign timer_clear  = release_grant || (state_q == StIdle);

  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    timeout_d     = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = rr_pick(last_q);
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (done_a || !req_a || expire) begin
          release_grant = 1'b1;
          last_d        = ServedA;
          // A normal release wins over a coincident expiry.
          timeout_d     = expire && !done_a && req_a;
          state_d       = req_b ? StGntB : StIdle;
        end
      end
      StGntB: begin
        if (done_b || !req_b || expire) begin
          release_grant = 1'b1;
          last_d        = ServedB;
          timeout_d     = expire && !done_b && req_b;
          state_d       = req_a ? StGntA : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    sel_d = sel_for(state_d, sel_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= ServedB;
      sel_q     <= SEL_A;
      timeout_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      gnt_a_q   <= (state_d == StGntA);
      gnt_b_q   <= (state_d == StGntB);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: a cycle model predicts each edge's outputs,
// a monitor compares them a moment after the edge, plus directed timing and invariant checks.
module tb_mux_select_arbiter;

  localparam int unsigned MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, done_a = 1'b0, done_b = 1'b0;
  logic gnt_a, gnt_b, sel, busy, timeout;

  int checks = 0;
  int errors = 0;

  mux_select_arbiter #(
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .done_a  (done_a),
    .done_b  (done_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: owner 0=none 1=A 2=B, held = cycles the current owner has had the path.
  int   m_owner = 0;
  int   m_last  = 2;
  int   m_held  = 0;
  logic m_sel   = 1'b0;
  logic m_to    = 1'b0;
  logic [4:0] sb[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_last = 2; m_held = 0; m_sel = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner != 0) begin
        logic dn, rq, other;
        dn    = (m_owner == 1) ? done_a : done_b;
        rq    = (m_owner == 1) ? req_a : req_b;
        other = (m_owner == 1) ? req_b : req_a;
        m_held++;
        if (dn || !rq || (MH != 0 && m_held == int'(MH))) begin
          m_to    = !dn && rq;
          m_last  = m_owner;
          m_owner = other ? 3 - m_owner : 0;
          m_held  = 0;
        end
      end else begin
        if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
        else if (req_a)     m_owner = 1;
        else if (req_b)     m_owner = 2;
        m_held = 0;
      end
      if (m_owner != 0) m_sel = (m_owner == 2);
    end
    sb.push_back({m_owner == 1, m_owner == 2, m_sel, m_owner != 0, m_to});
  end

  // Monitor: scoreboard compare plus structural invariants.
  int   starve_a = 0, starve_b = 0;
  logic prev_ga = 1'b0, prev_gb = 1'b0;

  always @(posedge clk) begin
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      logic [4:0] exp;
      exp = sb.pop_front();
      check("outputs", {27'd0, gnt_a, gnt_b, sel, busy, timeout}, {27'd0, exp});
    end
    check("one_hot", {31'd0, gnt_a & gnt_b}, 32'd0);
    if (busy) check("sel_match", {31'd0, sel}, {31'd0, gnt_b});
    if (rst_n && req_a && !gnt_a) begin
      if (gnt_b && !prev_gb) begin
        starve_a++;
        check("starve_a", {31'd0, starve_a > 1}, 32'd0);
      end
    end else starve_a = 0;
    if (rst_n && req_b && !gnt_b) begin
      if (gnt_a && !prev_ga) begin
        starve_b++;
        check("starve_b", {31'd0, starve_b > 1}, 32'd0);
      end
    end else starve_b = 0;
    prev_ga = gnt_a;
    prev_gb = gnt_b;
  end

  initial begin
    int hi_cnt, to_cnt;
    bit seen;

    // Reset then idle.
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_sel", {31'd0, sel}, 32'd0);

    // Single requester A, then B.
    req_a = 1'b1;
    cyc(1);
    check("a_grant_lat", {30'd0, gnt_a, sel}, {30'd0, 1'b1, 1'b0});
    cyc(4);
    done_a = 1'b1;
    cyc(1);
    done_a = 1'b0; req_a = 1'b0;
    check("a_release", {31'd0, gnt_a}, 32'd0);
    check("sel_holds_idle", {31'd0, sel}, 32'd0);
    req_b = 1'b1;
    cyc(1);
    check("b_grant_lat", {30'd0, gnt_b, sel}, {30'd0, 1'b1, 1'b1});
    done_b = 1'b1;
    cyc(1);
    done_b = 1'b0; req_b = 1'b0;
    cyc(2);
    check("sel_holds_b", {31'd0, sel}, 32'd1);

    // Tie and strict round-robin from reset.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1;
    cyc(1);
    check("tie_first_a", {30'd0, gnt_a, gnt_b}, 32'd2);
    for (int r = 0; r < 4; r++) begin
      cyc(2);
      done_a = 1'b1;
      cyc(1);
      done_a = 1'b0;
      check("rr_to_b", {29'd0, gnt_a, gnt_b, sel}, 32'd3);
      cyc(2);
      done_b = 1'b1;
      cyc(1);
      done_b = 1'b0;
      check("rr_to_a", {29'd0, gnt_a, gnt_b, sel}, 32'd4);
    end
    req_a = 1'b0; req_b = 1'b0;
    cyc(2);

    // Timeout: grant held exactly MH cycles, one timeout pulse.
    req_a = 1'b1;
    cyc(1);
    hi_cnt = gnt_a ? 1 : 0;
    to_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      if (timeout) begin
        to_cnt++; seen = 1'b1; req_a = 1'b0;
        check("to_drops_gnt", {31'd0, gnt_a}, 32'd0);
      end else if (gnt_a) hi_cnt++;
    end
    check("to_seen", {31'd0, seen}, 32'd1);
    check("to_hold_cycles", hi_cnt, MH);
    cyc(1);
    check("to_one_cycle", {31'd0, timeout}, 32'd0);
    cyc(2);

    // done_a on the expiry cycle: normal release, no pulse.
    req_a = 1'b1;
    cyc(1);
    cyc(int'(MH) - 1);
    check("pre_expiry_gnt", {31'd0, gnt_a}, 32'd1);
    done_a = 1'b1;
    cyc(1);
    done_a = 1'b0; req_a = 1'b0;
    check("done_at_expiry_to", {31'd0, timeout}, 32'd0);
    check("done_at_expiry_gnt", {31'd0, gnt_a}, 32'd0);
    cyc(2);

    // Reset mid-grant.
    req_b = 1'b1;
    cyc(1);
    check("mid_gnt_b", {29'd0, gnt_b, sel, busy}, 32'd7);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("mid_reset", {28'd0, gnt_b, sel, busy, timeout}, 32'd0);
    req_a = 1'b1;
    cyc(1);
    check("post_reset_tie_a", {30'd0, gnt_a, gnt_b}, 32'd2);
    req_a = 1'b0; req_b = 1'b0;
    cyc(2);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      done_a = ($urandom_range(5) == 0);
      done_b = ($urandom_range(5) == 0);
      cyc(1);
    end
    req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
    cyc(3);
    check("sb_drain", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
